// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake on both sides and zero/overflow/illegal flags.
// Optional iterative shift-add multiplier is built only when ALU_MUL_EN is defined.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
`ifdef ALU_MUL_EN
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam int         CNT_W   = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1, MULS = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1} state_t;
`endif

    state_t state, state_nxt;

    logic signed [WIDTH-1:0] sum_c, diff_c;
    logic [WIDTH-1:0]        res_c;
    logic                    ovf_c, ill_c, mul_c, add_ovf, sub_ovf, accept;

    function automatic logic add_overflow(input logic sa, input logic sb, input logic ss);
        return (sa == sb) && (ss != sa);
    endfunction

    function automatic logic sub_overflow(input logic sa, input logic sb, input logic sd);
        return (sa != sb) && (sd != sa);
    endfunction

    assign sum_c   = $signed(src_a) + $signed(src_b);
    assign diff_c  = $signed(src_a) - $signed(src_b);
    assign add_ovf = add_overflow(src_a[WIDTH-1], src_b[WIDTH-1], sum_c[WIDTH-1]);
    assign sub_ovf = sub_overflow(src_a[WIDTH-1], src_b[WIDTH-1], diff_c[WIDTH-1]);

    always_comb begin
        res_c = '0;
        ovf_c = 1'b0;
        ill_c = 1'b0;
        mul_c = 1'b0;
        case (alu_ctrl)
            ALU_AND: res_c = src_a & src_b;
            ALU_OR:  res_c = src_a | src_b;
            ALU_ADD: begin
                res_c = sum_c;
                ovf_c = add_ovf;
            end
            ALU_SUB: begin
                res_c = diff_c;
                ovf_c = sub_ovf;
            end
            ALU_SLT: res_c = {{(WIDTH-1){1'b0}}, diff_c[WIDTH-1] ^ sub_ovf};
            ALU_NOR: res_c = ~(src_a | src_b);
`ifdef ALU_MUL_EN
            ALU_MUL: mul_c = 1'b1;
`endif
            default: ill_c = 1'b1;
        endcase
    end

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mcand_p1, mplier_p1, acc_p1, acc_nxt;
    logic [CNT_W-1:0] cnt_p1;
    logic             mul_last;

    assign acc_nxt  = acc_p1 + (mplier_p1[0] ? mcand_p1 : '0);
    assign mul_last = (state == MULS) && (cnt_p1 == CNT_W'(WIDTH-1));

    // Multiplier stage: one shift-add iteration per cycle while in MULS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_p1  <= '0;
            mplier_p1 <= '0;
            acc_p1    <= '0;
            cnt_p1    <= '0;
        end else if (accept && mul_c) begin
            mcand_p1  <= src_a;
            mplier_p1 <= src_b;
            acc_p1    <= '0;
            cnt_p1    <= '0;
        end else if (state == MULS) begin
            mcand_p1  <= mcand_p1 << 1;
            mplier_p1 <= mplier_p1 >> 1;
            acc_p1    <= acc_nxt;
            cnt_p1    <= cnt_p1 + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = mul_c ? state_t'(2'd2) : DONE;
            end
            DONE: begin
                if (out_ready) begin
                    if (accept) state_nxt = mul_c ? state_t'(2'd2) : DONE;
                    else        state_nxt = IDLE;
                end
            end
`ifdef ALU_MUL_EN
            MULS: begin
                if (mul_last) state_nxt = DONE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Result stage: loaded on a simple/illegal accept or on the final multiply step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
        end else if (accept && !mul_c) begin
            result   <= res_c;
            zero     <= (res_c == '0);
            overflow <= ovf_c;
            illegal  <= ill_c;
        end
`ifdef ALU_MUL_EN
        else if (mul_last) begin
            result   <= acc_nxt;
            zero     <= (acc_nxt == '0);
            overflow <= 1'b0;
            illegal  <= 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized bench for alu_exec_unit against a transaction-level reference model.
// Honours ALU_MUL_EN the same way as the design.
module tb_alu_exec_unit;

    localparam int W = 32;
    localparam longint MAXS = (64'sd1 <<< (W-1)) - 64'sd1;
    localparam longint MINS = -(64'sd1 <<< (W-1));

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] src_a, src_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero, overflow, illegal;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .overflow(overflow), .illegal(illegal)
    );

    int checks = 0;
    int errors = 0;

    // reference model: a pending result plus multiply cycles still to run
    bit           m_valid;
    int           mul_left;
    logic [W-1:0] m_res, p_res;
    bit           m_ovf, m_ill;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void ref_eval(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] r, output bit o, output bit il, output bit mul);
        longint sa, sb, s;
        longint unsigned prod;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; o = 0; il = 0; mul = 0;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin s = sa + sb; r = W'(s); o = (s > MAXS) || (s < MINS); end
            4'b0110: begin s = sa - sb; r = W'(s); o = (s > MAXS) || (s < MINS); end
            4'b0111: r = {{(W-1){1'b0}}, (sa < sb)};
            4'b1100: r = ~(a | b);
`ifdef ALU_MUL_EN
            4'b1000: begin
                prod = longint'(a) * longint'(b);
                r = W'(prod);
                mul = 1;
            end
`endif
            default: il = 1;
        endcase
    endfunction

    // Drive one cycle (called at posedge+1), check against the model, advance one edge.
    task automatic step(input bit v, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit ordy, input string tag);
        bit           exp_rdy, acc, o, il, mul;
        logic [W-1:0] r;
        in_valid = v; alu_ctrl = c; src_a = a; src_b = b; out_ready = ordy;
        #1;
        exp_rdy = (mul_left == 0) && (!m_valid || ordy);
        check({tag, "_in_ready"}, W'(in_ready), W'(exp_rdy));
        check({tag, "_out_valid"}, W'(out_valid), W'(m_valid));
        if (m_valid) begin
            check({tag, "_result"}, result, m_res);
            check({tag, "_zero"}, W'(zero), W'(m_res == '0));
            check({tag, "_overflow"}, W'(overflow), W'(m_ovf));
            check({tag, "_illegal"}, W'(illegal), W'(m_ill));
        end
        acc = v && exp_rdy;
        ref_eval(c, a, b, r, o, il, mul);
        @(posedge clk);
        if (m_valid && ordy) m_valid = 0;
        if (mul_left > 0) begin
            mul_left--;
            if (mul_left == 0) begin
                m_valid = 1; m_res = p_res; m_ovf = 0; m_ill = 0;
            end
        end else if (acc) begin
            if (mul) begin
                mul_left = W; p_res = r;
            end else begin
                m_valid = 1; m_res = r; m_ovf = o; m_ill = il;
            end
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, W'(out_valid), '0);
        check({tag, "_result"}, result, '0);
        check({tag, "_zero"}, W'(zero), '0);
        check({tag, "_overflow"}, W'(overflow), '0);
        check({tag, "_illegal"}, W'(illegal), '0);
        check({tag, "_in_ready"}, W'(in_ready), W'(1'b1));
    endtask

    logic [3:0] codes [8];

    initial begin
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000, 4'b0011};
        m_valid = 0; mul_left = 0; m_res = '0; p_res = '0; m_ovf = 0; m_ill = 0;
        rst_n = 1'b0; in_valid = 1'b0; alu_ctrl = '0; src_a = '0; src_b = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // ADD 7+5
        step(1, 4'b0010, 32'd7, 32'd5, 0, "t1_acc");
        check("t1_valid", W'(out_valid), W'(1'b1));
        check("t1_res", result, 32'd12);
        check("t1_zero", W'(zero), '0);
        check("t1_ovf", W'(overflow), '0);
        step(0, 4'b0000, 32'd0, 32'd0, 1, "t1_drain");

        // SUB to zero, then ADD overflow accepted on the consuming edge
        step(1, 4'b0110, 32'd5, 32'd5, 0, "t2_sub");
        check("t2_sub_res", result, 32'd0);
        check("t2_sub_zero", W'(zero), W'(1'b1));
        step(1, 4'b0010, 32'h7FFF_FFFF, 32'd1, 1, "t2_add");
        check("t2_add_res", result, 32'h8000_0000);
        check("t2_add_ovf", W'(overflow), W'(1'b1));

        // SLT signed compares and NOR
        step(1, 4'b0111, 32'hFFFF_FFFF, 32'd1, 1, "t3_slt1");
        check("t3_slt1_res", result, 32'd1);
        step(1, 4'b0111, 32'd1, 32'hFFFF_FFFF, 1, "t3_slt2");
        check("t3_slt2_res", result, 32'd0);
        step(1, 4'b1100, 32'd0, 32'd0, 1, "t3_nor");
        check("t3_nor_res", result, 32'hFFFF_FFFF);
        step(0, 4'b0000, 32'd0, 32'd0, 1, "t3_drain");

        // back-pressure: result held, then consume and accept on the same edge
        step(1, 4'b0010, 32'd3, 32'd4, 0, "t4_add");
        for (int i = 0; i < 3; i++) begin
            step(1, 4'b0001, $urandom, $urandom, 0, "t4_hold");
            check("t4_hold_res", result, 32'd7);
            check("t4_hold_rdy", W'(in_ready), '0);
        end
        step(1, 4'b0000, 32'hF0, 32'h3C, 1, "t4_and");
        check("t4_and_valid", W'(out_valid), W'(1'b1));
        check("t4_and_res", result, 32'h30);
        step(0, 4'b0000, 32'd0, 32'd0, 1, "t4_drain");

`ifdef ALU_MUL_EN
        step(1, 4'b1000, 32'd6, 32'd7, 0, "t5_mul");
        for (int i = 0; i < W; i++) begin
            check("t5_busy_rdy", W'(in_ready), '0);
            step(1, 4'b0010, $urandom, $urandom, 0, "t5_busy");
        end
        check("t5_valid", W'(out_valid), W'(1'b1));
        check("t5_res", result, 32'd42);
        step(0, 4'b0000, 32'd0, 32'd0, 1, "t5_drain");

        step(1, 4'b1000, $urandom, $urandom, 0, "t6_mul");
        repeat (10) step(0, 4'b0000, 32'd0, 32'd0, 0, "t6_iter");
`else
        step(1, 4'b1000, 32'd6, 32'd7, 0, "t5_mul");
        check("t5_illegal", W'(illegal), W'(1'b1));
        check("t5_res", result, 32'd0);
        check("t5_zero", W'(zero), W'(1'b1));
        step(0, 4'b0000, 32'd0, 32'd0, 1, "t5_drain");

        step(1, 4'b0010, 32'd9, 32'd9, 0, "t6_add");
`endif
        // asynchronous reset mid-operation
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        m_valid = 0; mul_left = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("t6_rst_hold");
        rst_n = 1'b1;
        step(1, 4'b0001, 32'h0F00, 32'h00F0, 0, "t6_after");
        check("t6_after_res", result, 32'h0FF0);
        step(0, 4'b0000, 32'd0, 32'd0, 1, "t6_drain");

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [3:0]   c;
            logic [W-1:0] a, b;
            int           sel;
            sel = $urandom_range(0, 7);
            c = (sel == 7) ? 4'($urandom) : codes[sel];
            a = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : W'($urandom);
            if ($urandom_range(0, 9) == 0) b = a;
            step(1'($urandom_range(0, 1)), c, a, b, ($urandom_range(0, 3) != 0), "rnd");
        end
        for (int n = 0; n < W + 2; n++) step(0, 4'b0000, 32'd0, 32'd0, 1, "final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
